// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the clock time counter.
package clock_pkg;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  localparam logic [7:0] SEC_MAX     = 8'h59;
  localparam logic [7:0] MIN_MAX     = 8'h59;
  localparam logic [7:0] HOUR_MAX_24 = 8'h23;
  localparam logic [7:0] HOUR_MAX_12 = 8'h12;

  // True when both nibbles are decimal digits and the pair lies in [lo, hi].
  // With valid nibbles, packed BCD orders the same way as binary.
  function automatic logic bcd_pair_valid(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit packed BCD counter running MIN..MAX, wrapping MAX -> MIN.
// Load takes precedence over increment; wrap flags an increment taken at MAX.
module bcd_pair_counter #(
  parameter logic [7:0] MIN     = 8'h00,
  parameter logic [7:0] MAX     = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q, value_d, next_val;

  // Next value on increment: wrap at MAX, else BCD +1 with digit carry.
  always_comb begin
    next_val = value_q;
    if (value_q == MAX) begin
      next_val = MIN;
    end else if (value_q[3:0] == 4'd9) begin
      next_val = {value_q[7:4] + 4'd1, 4'd0};
    end else begin
      next_val = {value_q[7:4], value_q[3:0] + 4'd1};
    end
  end

  // Select load, increment or hold.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = next_val;
    end
  end

  // Pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RST_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = inc && (value_q == MAX);

endmodule

// File: rtl/clock_time_counter.sv
// Timekeeping core: 1 Hz prescaler plus HH:MM:SS packed BCD time of day with
// load and per-field adjust. Define CLOCK_12H_EN for 12 h mode with PM flag.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  input  logic        adj_min,
  input  logic        adj_hour,
  output logic [23:0] number_sig,
  output logic        sec_tick,
  output logic        set_err,
  output logic        pm
);

  localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_HZ - 1);

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HourMin = 8'h01;
  localparam logic [7:0] HourMax = HOUR_MAX_12;
  localparam logic [7:0] HourRst = 8'h12;
`else
  localparam logic [7:0] HourMin = 8'h00;
  localparam logic [7:0] HourMax = HOUR_MAX_24;
  localparam logic [7:0] HourRst = 8'h00;
`endif

  bcd_time_t  set_t;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic       tick, load_ok, adj_any;
  logic       sec_inc, min_inc, hour_inc;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic [7:0] ss, mm, hh;
  logic       sec_tick_q, set_err_q;

  assign set_t   = set_time;
  assign tick    = run_en && (pre_cnt_q == PreMax);
  assign load_ok = set_valid && bcd_pair_valid(set_t.hh, HourMin, HourMax) &&
                   bcd_pair_valid(set_t.mm, 8'h00, MIN_MAX) &&
                   bcd_pair_valid(set_t.ss, 8'h00, SEC_MAX);
  assign adj_any = adj_min || adj_hour;

  // Increment gating: a load blocks everything; an adjust drops tick carries.
  always_comb begin
    sec_inc  = tick && !set_valid;
    min_inc  = !set_valid && (adj_min || (sec_wrap && !adj_any));
    hour_inc = !set_valid && (adj_hour || (min_wrap && !adj_any));
  end

  // Prescaler next state: cleared by an accepted load, frozen when stopped.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (load_ok) begin
      pre_cnt_d = '0;
    end else if (run_en) begin
      pre_cnt_d = (pre_cnt_q == PreMax) ? '0 : pre_cnt_q + PreW'(1);
    end
  end

  // Prescaler and status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q  <= '0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      sec_tick_q <= sec_inc;
      set_err_q  <= set_valid && !load_ok;
    end
  end

  bcd_pair_counter #(
    .MIN     (8'h00),
    .MAX     (SEC_MAX),
    .RST_VAL (8'h00)
  ) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_ok),
    .load_val (set_t.ss),
    .inc      (sec_inc),
    .value    (ss),
    .wrap     (sec_wrap)
  );

  bcd_pair_counter #(
    .MIN     (8'h00),
    .MAX     (MIN_MAX),
    .RST_VAL (8'h00)
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_ok),
    .load_val (set_t.mm),
    .inc      (min_inc),
    .value    (mm),
    .wrap     (min_wrap)
  );

  bcd_pair_counter #(
    .MIN     (HourMin),
    .MAX     (HourMax),
    .RST_VAL (HourRst)
  ) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_ok),
    .load_val (set_t.hh),
    .inc      (hour_inc),
    .value    (hh),
    .wrap     (hour_wrap)
  );

`ifdef CLOCK_12H_EN
  logic pm_q;

  // PM flips whenever hours step 11 -> 12; loads leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q <= 1'b0;
    end else if (hour_inc && !load_ok && (hh == 8'h11)) begin
      pm_q <= !pm_q;
    end
  end

  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  assign number_sig = {hh, mm, ss};
  assign sec_tick   = sec_tick_q;
  assign set_err    = set_err_q;

  // Hours wrap has no further carry in either mode.
  logic unused_hour_wrap;
  assign unused_hour_wrap = hour_wrap;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter with CLK_HZ=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_clock_time_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        set_valid;
  logic [23:0] set_time;
  logic        adj_min;
  logic        adj_hour;
  logic [23:0] number_sig;
  logic        sec_tick;
  logic        set_err;
  logic        pm;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  clock_time_counter #(
    .CLK_HZ (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .set_valid  (set_valid),
    .set_time   (set_time),
    .adj_min    (adj_min),
    .adj_hour   (adj_hour),
    .number_sig (number_sig),
    .sec_tick   (sec_tick),
    .set_err    (set_err),
    .pm         (pm)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle load request; returns at the falling edge after the load edge.
  task automatic load(input logic [23:0] val);
    set_valid = 1'b1;
    set_time  = val;
    cyc(1);
    set_valid = 1'b0;
  endtask

  // From a prescaler count of 0: three quiet edges, then the tick edge.
  task automatic one_tick(input string tag, input logic [23:0] exp_time);
    cyc(3);
    check_eq({tag, "_quiet"}, 32'(sec_tick), 32'd0);
    cyc(1);
    check_eq({tag, "_tick"}, 32'(sec_tick), 32'd1);
    check_eq({tag, "_time"}, 32'(number_sig), 32'(exp_time));
  endtask

  initial begin
    rst_n     = 1'b0;
    run_en    = 1'b1;
    set_valid = 1'b0;
    set_time  = '0;
    adj_min   = 1'b0;
    adj_hour  = 1'b0;
    cyc(3);

`ifdef CLOCK_12H_EN
    check_eq("rst_time", 32'(number_sig), 32'h120000);
    check_eq("rst_pm", 32'(pm), 32'd0);
    rst_n = 1'b1;
    one_tick("first", 24'h120001);

    load(24'h115959);
    check_eq("ld_1159", 32'(number_sig), 32'h115959);
    one_tick("to_noon", 24'h120000);
    check_eq("pm_set", 32'(pm), 32'd1);

    load(24'h125959);
    one_tick("to_one", 24'h010000);
    check_eq("pm_kept", 32'(pm), 32'd1);

    load(24'h130000);
    check_eq("rej13_err", 32'(set_err), 32'd1);
    check_eq("rej13_time", 32'(number_sig), 32'h010000);
    load(24'h000000);
    check_eq("rej00_err", 32'(set_err), 32'd1);

    load(24'h110000);
    adj_hour = 1'b1;
    cyc(1);
    adj_hour = 1'b0;
    check_eq("adjh_time", 32'(number_sig), 32'h120000);
    check_eq("adjh_pm", 32'(pm), 32'd0);
`else
    check_eq("rst_time", 32'(number_sig), 32'h000000);
    check_eq("rst_tick", 32'(sec_tick), 32'd0);
    check_eq("rst_err", 32'(set_err), 32'd0);
    check_eq("rst_pm", 32'(pm), 32'd0);
    rst_n = 1'b1;
    one_tick("first", 24'h000001);
    cyc(1);
    check_eq("tick_width", 32'(sec_tick), 32'd0);

    // Rollover through midnight, ticks four cycles apart.
    load(24'h235958);
    check_eq("ld_ok", 32'(number_sig), 32'h235958);
    check_eq("ld_noerr", 32'(set_err), 32'd0);
    one_tick("t1", 24'h235959);
    one_tick("t2", 24'h000000);

    // Rejected loads leave the time alone and pulse set_err once.
    load(24'h245900);
    check_eq("rej24_err", 32'(set_err), 32'd1);
    check_eq("rej24_time", 32'(number_sig), 32'h000000);
    load(24'h12A000);
    check_eq("rejA_err", 32'(set_err), 32'd1);
    check_eq("rejA_time", 32'(number_sig), 32'h000000);
    cyc(1);
    check_eq("rej_pulse", 32'(set_err), 32'd0);

    // Adjust on the tick edge: seconds advance, carries dropped.
    load(24'h105959);
    cyc(3);
    adj_min = 1'b1;
    cyc(1);
    adj_min = 1'b0;
    check_eq("adj_tick_time", 32'(number_sig), 32'h100000);
    check_eq("adj_tick_tick", 32'(sec_tick), 32'd1);

    load(24'h230000);
    adj_hour = 1'b1;
    cyc(1);
    adj_hour = 1'b0;
    check_eq("adjh_wrap", 32'(number_sig), 32'h000000);

    load(24'h125900);
    adj_min  = 1'b1;
    adj_hour = 1'b1;
    cyc(1);
    adj_min  = 1'b0;
    adj_hour = 1'b0;
    check_eq("adj_both", 32'(number_sig), 32'h130000);

    // Load wins over a simultaneous adjust.
    adj_min = 1'b1;
    load(24'h101010);
    adj_min = 1'b0;
    check_eq("ld_over_adj", 32'(number_sig), 32'h101010);

    // Freeze: no ticks, adjust still applies, count resumes from 0.
    load(24'h010203);
    run_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) adj_min = 1'b1;
      cyc(1);
      adj_min = 1'b0;
      check_eq("frz_tick", 32'(sec_tick), 32'd0);
    end
    check_eq("frz_time", 32'(number_sig), 32'h010303);
    run_en = 1'b1;
    one_tick("resume", 24'h010304);

    // Asynchronous reset mid-count.
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_time", 32'(number_sig), 32'h000000);
    check_eq("arst_tick", 32'(sec_tick), 32'd0);
    check_eq("arst_err", 32'(set_err), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    one_tick("post_rst", 24'h000001);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
